// File: rtl/gpio_irq_ctrl_if.sv
// APB bus bundle for gpio_irq_ctrl.
// The CPU/bridge side uses the master modport. The controller uses the slave modport.
// The signal names follow the AMBA APB names so that waveforms read naturally.
interface gpio_irq_ctrl_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA,
        input  PREADY
    );

    modport slave (
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA,
        output PREADY
    );

endinterface : gpio_irq_ctrl_if

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: latches per-pin GPIO interrupt pulses into pending bits.
// It masks the pending bits and picks the lowest-index active source.
// It drives one level interrupt to the CPU, with claim/complete handshaking over APB.
//
// Optional feature: define GPIO_IRQ_CTRL_OVF_EN to build the OVF register at
// word offset 5. That register records events lost on an already-pending source.
// Without the macro, offset 5 reads 0 and no OVF state exists.
//
// Register map (word offsets, PADDR[4:2]):
//   0 PENDING  R / W1C
//   1 MASK     R/W, 1 = enabled
//   2 CLAIM    RO, reading in ASSERT claims the winner
//   3 COMPLETE WO, reads 0
//   4 CTRL     bit0 global enable
//   5 OVF      R / W1C (optional)
//   6..7       read 0, writes ignored
module gpio_irq_ctrl #(
    parameter int N_SRCS = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [N_SRCS-1:0] irq_i,
    gpio_irq_ctrl_if.slave    apb,
    output logic              irq_o
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    // The encoding puts the interrupt level in bit 0.
    // That makes irq_o a direct flop output with no decode logic behind it.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_SERVICE = 2'b10
    } state_e;

    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_MASK     = 3'd1;
    localparam logic [2:0] OFF_CLAIM    = 3'd2;
    localparam logic [2:0] OFF_COMPLETE = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_OVF      = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [N_SRCS-1:0] pend_q,  pend_d;
    logic [N_SRCS-1:0] mask_q,  mask_d;
    logic              en_q,    en_d;
    logic [4:0]        svc_id_q, svc_id_d;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       rd_acc;
    logic       wr_acc;
    logic [2:0] addr;

    assign rd_acc = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign wr_acc = apb.PSEL & apb.PENABLE &  apb.PWRITE;
    assign addr   = apb.PADDR[4:2];

    // Zero wait states: every access completes in its first access cycle.
    assign apb.PREADY = apb.PSEL & apb.PENABLE;

    // Only PADDR[4:2] is decoded. PWDATA is used only as wide as each register.
    logic unused_bits;
    assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N_SRCS-1:0] active;
    logic              any_active;
    logic [4:0]        win_id;

    assign active     = pend_q & mask_q;
    assign any_active = |active;

    // Fixed priority: lowest set index of active wins. The scan runs downward so the last hit is the lowest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_id = '0;
        for (int i = N_SRCS - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = 5'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Side-effecting accesses
    // ------------------------------------------------------------------
    logic              claim_fire;
    logic              complete_fire;
    logic [N_SRCS-1:0] claim_clr;
    logic [N_SRCS-1:0] w1c_clr;
    logic [N_SRCS-1:0] pend_clr;

    // A claim only counts when there is something to hand out. A stale ASSERT
    // cycle (mask just dropped) therefore returns 0 instead of a bogus id.
    assign claim_fire    = rd_acc && (addr == OFF_CLAIM) &&
                           (state_q == ST_ASSERT) && any_active;
    assign complete_fire = wr_acc && (addr == OFF_COMPLETE) &&
                           (state_q == ST_SERVICE) && (apb.PWDATA[4:0] == svc_id_q);

    assign claim_clr = claim_fire ? (N_SRCS'(1) << win_id) : '0;
    assign w1c_clr   = (wr_acc && (addr == OFF_PENDING)) ? apb.PWDATA[N_SRCS-1:0] : '0;
    assign pend_clr  = claim_clr | w1c_clr;

    // ------------------------------------------------------------------
    // Optional overflow tracking
    // ------------------------------------------------------------------
    logic [31:0] ovf_rdata;

`ifdef GPIO_IRQ_CTRL_OVF_EN
    logic [N_SRCS-1:0] ovf_q, ovf_d;
    logic [N_SRCS-1:0] ovf_clr;

    assign ovf_clr = (wr_acc && (addr == OFF_OVF)) ? apb.PWDATA[N_SRCS-1:0] : '0;

    // An event is lost when its pending bit is already set and is not being cleared this cycle. A new loss beats a W1C.
    always_comb begin
        ovf_d = (ovf_q & ~ovf_clr) | (irq_i & pend_q & ~pend_clr);
    end

    // Overflow flag register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_rdata = 32'(ovf_q);
`else
    assign ovf_rdata = '0;
`endif

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    // A new event beats a clear on the same bit, so a W1C racing a pulse cannot lose it.
    always_comb begin
        pend_d   = (pend_q & ~pend_clr) | irq_i;
        mask_d   = mask_q;
        en_d     = en_q;
        svc_id_d = svc_id_q;

        if (wr_acc && (addr == OFF_MASK)) begin
            mask_d = apb.PWDATA[N_SRCS-1:0];
        end
        if (wr_acc && (addr == OFF_CTRL)) begin
            en_d = apb.PWDATA[0];
        end
        if (claim_fire) begin
            svc_id_d = win_id;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    // Next-state logic of the IDLE -> ASSERT -> SERVICE handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_q && any_active) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (claim_fire) begin
                    state_d = ST_SERVICE;
                end else if (!(en_q && any_active)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (complete_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file and FSM state. All of it clears asynchronously on PRESET.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            mask_q   <= '0;
            en_q     <= 1'b0;
            svc_id_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            en_q     <= en_d;
            svc_id_q <= svc_id_d;
        end
    end

    assign irq_o = state_q[0];

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Combinational read data. It is driven only during a read access phase and is 0 otherwise.
    always_comb begin
        apb.PRDATA = '0;
        if (rd_acc) begin
            case (addr)
                OFF_PENDING: apb.PRDATA = 32'(pend_q);
                OFF_MASK:    apb.PRDATA = 32'(mask_q);
                OFF_CLAIM:   apb.PRDATA = claim_fire ? {1'b1, 26'b0, win_id} : 32'h0;
                OFF_CTRL:    apb.PRDATA = {31'b0, en_q};
                OFF_OVF:     apb.PRDATA = ovf_rdata;
                default:     apb.PRDATA = '0;
            endcase
        end
    end

endmodule : gpio_irq_ctrl

// File: tb/tb_gpio_irq_ctrl.sv
// Directed testbench for gpio_irq_ctrl.
// The stimulus process pushes hand-computed expected values into queues.
// A negedge monitor pops them and compares whenever the DUT presents read
// data (APB access phase), or when a line probe was queued that cycle.
module tb_gpio_irq_ctrl;

    localparam int N = 8;

    localparam logic [31:0] A_PENDING  = 32'h00;
    localparam logic [31:0] A_MASK     = 32'h04;
    localparam logic [31:0] A_CLAIM    = 32'h08;
    localparam logic [31:0] A_COMPLETE = 32'h0C;
    localparam logic [31:0] A_CTRL     = 32'h10;
    localparam logic [31:0] A_OVF      = 32'h14;
    localparam logic [31:0] A_RSVD6    = 32'h18;
    localparam logic [31:0] A_RSVD7    = 32'h1C;

    localparam int SEL_IRQ    = 0;
    localparam int SEL_PREADY = 1;
    localparam int SEL_PRDATA = 2;

`ifdef GPIO_IRQ_CTRL_OVF_EN
    localparam logic [31:0] EXP_OVF = 32'h02;
`else
    localparam logic [31:0] EXP_OVF = 32'h00;
`endif

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic         PCLK;
    logic         PRESET;
    logic [N-1:0] irq_i;
    logic         irq_o;

    gpio_irq_ctrl_if apb();

    gpio_irq_ctrl #(.N_SRCS(N)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .irq_i  (irq_i),
        .apb    (apb),
        .irq_o  (irq_o)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t rd_q[$];
    exp_t pr_q[$];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: scores read data in every access phase and drains line probes.
    always @(negedge PCLK) begin
        exp_t        e;
        logic [31:0] act;
        if (apb.PSEL && apb.PENABLE) begin
            check("pready_in_access", {31'b0, apb.PREADY}, 32'h1);
            if (!apb.PWRITE) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", apb.PRDATA, 32'hDEAD_BEEF);
                end else begin
                    e = rd_q.pop_front();
                    check(e.name, apb.PRDATA, e.exp);
                end
            end
        end
        while (pr_q.size() > 0) begin
            e = pr_q.pop_front();
            case (e.sel)
                SEL_IRQ:    act = {31'b0, irq_o};
                SEL_PREADY: act = {31'b0, apb.PREADY};
                default:    act = apb.PRDATA;
            endcase
            check(e.name, act, e.exp);
        end
    end

    // Advances to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic probe(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        pr_q.push_back(e);
    endtask

    task automatic exp_irq(input string name, input logic v);
        probe(name, SEL_IRQ, {31'b0, v});
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [N-1:0] irq_acc = '0);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = addr; apb.PWDATA = data;
        tick();
        apb.PENABLE = 1'b1;
        irq_i = irq_acc;
        tick();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        irq_i = '0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.sel  = SEL_PRDATA;
        e.exp  = exp;
        rd_q.push_back(e);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = addr;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        irq_i = v;
        tick();
        irq_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1;
        irq_i = '0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        tick(); tick();
        exp_irq("rst_irq", 1'b0);
        probe("rst_pready", SEL_PREADY, 32'h0);
        probe("rst_prdata", SEL_PRDATA, 32'h0);
        tick();
        PRESET = 1'b0;
        tick();

        apb_read(A_PENDING, 32'h0, "rst_pending");
        apb_read(A_MASK,    32'h0, "rst_mask");
        apb_read(A_CTRL,    32'h0, "rst_ctrl");
        apb_read(A_CLAIM,   32'h0, "claim_idle");

        // Basic path: event -> irq two cycles later -> claim -> irq drops.
        apb_write(A_MASK, 32'h01);
        apb_write(A_CTRL, 32'h01);
        apb_read(A_CTRL, 32'h01, "t1_ctrl");
        pulse(8'h01);
        exp_irq("t1_irq_n1", 1'b0);
        tick();
        exp_irq("t1_irq_n2", 1'b1);
        apb_read(A_PENDING, 32'h01, "t1_pending");
        apb_read(A_CLAIM, 32'h8000_0000, "t1_claim");
        exp_irq("t1_irq_after_claim", 1'b0);
        apb_read(A_PENDING, 32'h00, "t1_pending_cleared");
        apb_write(A_COMPLETE, 32'h00);
        tick();
        exp_irq("t1_idle_quiet", 1'b0);

        // Priority: 0x28 latched while masked; bit 3 wins before bit 5.
        apb_write(A_MASK, 32'h00);
        pulse(8'h28);
        tick(); tick();
        exp_irq("t2_masked", 1'b0);
        apb_write(A_MASK, 32'h28);
        exp_irq("t2_irq_w0", 1'b0);
        tick();
        exp_irq("t2_irq_w1", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0003, "t2_claim3");
        exp_irq("t2_service", 1'b0);
        apb_write(A_COMPLETE, 32'h03);
        exp_irq("t2_complete_idle", 1'b0);
        tick();
        exp_irq("t2_reassert", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0005, "t2_claim5");
        apb_write(A_COMPLETE, 32'h05);
        apb_read(A_PENDING, 32'h00, "t2_pending_empty");

        // Handshake errors: mismatched COMPLETE keeps SERVICE.
        apb_write(A_MASK, 32'h04);
        pulse(8'h04);
        tick();
        exp_irq("t3_assert", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0002, "t3_claim2");
        apb_write(A_COMPLETE, 32'h04);
        pulse(8'h04);
        tick(); tick();
        exp_irq("t3_still_service", 1'b0);
        apb_read(A_CLAIM, 32'h0, "t3_claim_in_service");
        apb_read(A_PENDING, 32'h04, "t3_pending_in_service");
        apb_write(A_COMPLETE, 32'h02);
        exp_irq("t3_complete_idle", 1'b0);
        tick();
        exp_irq("t3_reassert", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0002, "t3_claim2_again");
        apb_write(A_COMPLETE, 32'h02);

        // Set beats clear, and multi-source capture while masked.
        apb_write(A_MASK, 32'h00);
        pulse(8'h04);
        apb_write(A_PENDING, 32'h04, 8'h04);
        apb_read(A_PENDING, 32'h04, "t4_set_wins");
        apb_write(A_PENDING, 32'h04);
        apb_read(A_PENDING, 32'h00, "t4_w1c");
        pulse(8'h81);
        tick(); tick();
        exp_irq("t4_masked_quiet", 1'b0);
        apb_read(A_PENDING, 32'h81, "t4_multi_capture");
        apb_write(32'hABC0_0004, 32'hFF);
        exp_irq("t4_mask_w0", 1'b0);
        tick();
        exp_irq("t4_mask_w1", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0000, "t4_claim0");
        apb_write(A_COMPLETE, 32'h00);
        exp_irq("t4_complete_idle", 1'b0);
        tick();
        exp_irq("t4_reassert", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0007, "t4_claim7");
        apb_write(A_COMPLETE, 32'h07);
        tick(); tick();
        exp_irq("t4_drained", 1'b0);

        // Disabling CTRL in ASSERT drops back to IDLE before a claim.
        pulse(8'h02);
        tick();
        exp_irq("t5_assert", 1'b1);
        apb_write(A_CTRL, 32'h00);
        exp_irq("t5_disable_w0", 1'b1);
        tick();
        exp_irq("t5_disable_w1", 1'b0);
        apb_read(A_CLAIM, 32'h0, "t5_claim_disabled");
        apb_read(A_CTRL, 32'h0, "t5_ctrl_off");
        apb_write(A_CTRL, 32'h01);
        exp_irq("t5_enable_w0", 1'b0);
        tick();
        exp_irq("t5_enable_w1", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0001, "t5_claim1");

        // Overflow (SERVICE, svc_id = 1) and reserved offsets.
        pulse(8'h02);
        tick();
        apb_read(A_OVF, 32'h0, "ovf_single");
        pulse(8'h02);
        tick();
        apb_read(A_OVF, EXP_OVF, "ovf_double");
        apb_write(A_OVF, 32'h02);
        apb_read(A_OVF, 32'h0, "ovf_w1c");
        exp_irq("ovf_no_irq", 1'b0);
        apb_read(A_RSVD6, 32'h0, "rsvd6_read");
        apb_write(A_RSVD7, 32'hFFFF_FFFF);
        apb_write(A_RSVD6, 32'h0);
        apb_read(A_MASK, 32'hFF, "rsvd_write_ignored");
        apb_read(A_COMPLETE, 32'h0, "complete_reads0");

        // Reset in SERVICE clears everything at once.
        PRESET = 1'b1;
        exp_irq("midrst_irq", 1'b0);
        tick();
        exp_irq("midrst_irq_hold", 1'b0);
        PRESET = 1'b0;
        tick();
        apb_read(A_PENDING, 32'h0, "midrst_pending");
        apb_read(A_MASK,    32'h0, "midrst_mask");
        apb_read(A_CTRL,    32'h0, "midrst_ctrl");
        apb_read(A_OVF,     32'h0, "midrst_ovf");
        apb_read(A_CLAIM,   32'h0, "midrst_claim");
        apb_write(A_MASK, 32'h01);
        apb_write(A_CTRL, 32'h01);
        pulse(8'h01);
        tick();
        exp_irq("midrst_fresh_assert", 1'b1);
        apb_read(A_CLAIM, 32'h8000_0000, "midrst_fresh_claim");
        apb_write(A_COMPLETE, 32'h00);

        tick(); tick();
        check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        check("probe_queue_drained", 32'(pr_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gpio_irq_ctrl

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

Interrupt controller for the GPIO block's per-pin interrupt pulses. It latches one-cycle `irq` pulses into pending bits and applies a mask. Pending sources are arbitrated by fixed priority, and a single level interrupt with claim/complete handshaking goes to the CPU. It is an APB slave on the same peripheral bus as the GPIO block, directly downstream of its `irq_o` vector.

## Interface
- `N_SRCS`, default 8: number of interrupt sources, range 1..31.
- `PCLK` in 1: the single clock.
- `PRESET` in 1: asynchronous reset, active-high.
- `irq_i` in N_SRCS: per-source event pulses from the GPIO block. Any cycle high is one event.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB enable.
- `PWRITE` in 1: APB write.
- `PADDR` in 32: APB address. Only [4:2] is decoded.
- `PWDATA` in 32: APB write data.
- `PRDATA` out 32: APB read data. 0 when not accessed.
- `PREADY` out 1: high exactly when PSEL && PENABLE (zero wait states).
- `irq_o` out 1: registered CPU interrupt line.

## Operation
Registers, at word offsets:
- 0 PENDING: read; write-1-to-clear.
- 1 MASK: R/W; 1 = enabled.
- 2 CLAIM: read-only, with side effect.
- 3 COMPLETE: write-only; reads return 0.
- 4 CTRL: bit0 global enable, R/W.
- 5 OVF: see Configuration.
- Offsets 6–7 read 0; writes to them are ignored.

Behaviour:
- `pend_set = irq_i`. A pending bit sets on an event and clears on a W1C write or a claim. If set and clear hit the same bit in the same cycle, set wins.
- `active = PENDING & MASK`. The winner is the lowest-index set bit of `active`.
- FSM `state`:
  - IDLE: `irq_o`=0. Go to ASSERT when CTRL.bit0 && |active.
  - ASSERT: `irq_o`=1.
    - A CLAIM read returns {1'b1, 26'b0, winner id[4:0]}, clears that pending bit, stores `svc_id`, and goes to SERVICE.
    - If `active` drops to 0, or CTRL.bit0 goes to 0, before a claim, go back to IDLE.
  - SERVICE: `irq_o`=0. A COMPLETE write with PWDATA[4:0]==`svc_id` goes to IDLE. Non-matching writes are ignored.
- A CLAIM read in IDLE or SERVICE returns 0 (bit31 = 0) and changes nothing.
- Pending bits keep accumulating while masked, disabled, or in SERVICE.

## Timing
- Reset values: all registers 0, state IDLE, `irq_o`=0, `PRDATA`=0, `PREADY`=0 (combinational, follows inputs), `svc_id`=0.
- Reset asserted mid-operation clears everything immediately, including an in-service claim.
- Register writes take effect on the PCLK edge that ends the access phase.
- Event to `irq_o`:
  - Event on `irq_i` at edge N sets PENDING at edge N+1.
  - The FSM enters ASSERT at N+2, and `irq_o` goes high after that edge.
  - Latency is 2 cycles from the event cycle.
- CLAIM: `PRDATA` is combinational in the access cycle. The pending clear and the move to SERVICE take effect at the following edge, so `irq_o` falls 1 cycle after the claim.
- COMPLETE while `active` is still nonzero: IDLE for one cycle, then ASSERT. `irq_o` re-rises 2 cycles after the COMPLETE access.
- Simultaneous events on several sources in one cycle are all captured, with no loss.

## Configuration
- `GPIO_IRQ_CTRL_OVF_EN` defined:
  - OVF register at offset 5, W1C.
  - A bit sets when an event arrives on a source whose PENDING bit is already 1 and is not being cleared in that cycle.
  - It never affects `irq_o`.
- Undefined: offset 5 reads 0, writes are ignored, and no OVF storage is synthesized.

## Test plan
- Reset: MASK=0x01, CTRL=1. Pulse irq_i=0x01 for one cycle. Expect PENDING=0x01 and `irq_o`=1 two cycles later. CLAIM returns 0x80000000. `irq_o`=0 next cycle.
- Priority: with `irq_o` low and both sources masked, pulse irq_i=0x28 in one cycle, then write MASK=0x28. First CLAIM returns 0x80000003. Then COMPLETE 3 → `irq_o` re-asserts 2 cycles later. Second CLAIM returns 0x80000005.
- Handshake errors:
  - CLAIM in IDLE returns 0.
  - In SERVICE with `svc_id`=2, COMPLETE 4 leaves the state in SERVICE. COMPLETE 2 returns to IDLE.
- Set vs clear:
  - Write PENDING W1C 0x04 in the same cycle as an irq_i[2] pulse → PENDING[2] stays 1.
  - With MASK=0, events set PENDING and `irq_o` stays 0. Writing MASK=0xFF asserts `irq_o` on the cycle after the write edge.
- Overflow (macro on): two pulses on irq_i[1] without a claim → OVF=0x02. W1C 0x02 → 0. With the macro off, offset 5 reads 0.
- Reset mid-service: assert PRESET in SERVICE → `irq_o`=0, all registers 0, and the next CLAIM returns 0.
